// File: rtl/exception_sequencer.sv
// Multicycle exception sequencer: captures EPC, fetches the handler vector byte, then loads PC.
// Build macro EXC_SEQ_DOUBLE_FAULT_EN adds the double_fault output and a terminal HALT state.
module exception_sequencer #(
   parameter int MEM_LAT  = 2,
   parameter int VEC_BASE = 253
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic [1:0]  ctrl_iord,
   input  logic [31:0] pc_i,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  iord_sel,
   output logic [31:0] excpt_addr,
   output logic        busy,
   output logic        epc_wr,
   output logic [31:0] epc_val,
   output logic        pc_wr,
   output logic [31:0] pc_vec,
   output logic [1:0]  cause,
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
   output logic        double_fault,
`endif
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EPC  = 3'd1,
      S_WAIT = 3'd2,
      S_LOAD = 3'd3
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
      , S_HALT = 3'd4
`endif
   } state_t;

   localparam logic [3:0]  CNT_INIT = 4'(MEM_LAT - 1);
   localparam logic [31:0] VEC_ADDR = 32'(VEC_BASE);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  cause_q, cause_d;
   logic [7:0]  vec_q, vec_d;
   logic        any_req;
   logic [1:0]  req_cause;
   logic        unused_rdata_hi;

   // Request/stall contract: exc_* are level requests, accepted only in IDLE;
   // while busy is high the main FSM holds and this block owns the address mux.
   assign any_req         = exc_opcode | exc_ovf | exc_div0;
   assign unused_rdata_hi = ^mem_rdata[31:8];

   always_comb begin
      if (exc_opcode)
         req_cause = 2'd0;
      else if (exc_ovf)
         req_cause = 2'd1;
      else
         req_cause = 2'd2;
   end

`ifdef EXC_SEQ_DOUBLE_FAULT_EN
   logic df_q;

   always_ff @(posedge clk) begin
      if (reset)
         df_q <= 1'b0;
      else if (state_q != S_IDLE && any_req)
         df_q <= 1'b1;
   end

   assign double_fault = df_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cause_q <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         vec_q   <= vec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      vec_d   = vec_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               cause_d = req_cause;
               state_d = S_EPC;
            end
         end
         S_EPC: begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Counter reaching zero marks the final wait cycle; data is valid at its closing edge.
            if (cnt_q == 4'd0) begin
               vec_d   = mem_rdata[7:0];
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_LOAD: begin
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
            state_d = (df_q || any_req) ? S_HALT : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      epc_wr   = 1'b0;
      pc_wr    = 1'b0;
      iord_sel = ctrl_iord;
      case (state_q)
         S_EPC: begin
            busy     = 1'b1;
            epc_wr   = 1'b1;
            iord_sel = 2'b11;
         end
         S_WAIT: begin
            busy     = 1'b1;
            iord_sel = 2'b11;
         end
         S_LOAD: begin
            busy     = 1'b1;
            pc_wr    = 1'b1;
            iord_sel = 2'b11;
         end
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
         S_HALT: begin
            busy     = 1'b1;
            iord_sel = 2'b11;
         end
`endif
         default: ;
      endcase
      if (reset)
         iord_sel = 2'b00;
   end

   assign excpt_addr = VEC_ADDR + {30'b0, cause_q};
   assign epc_val    = pc_i - 32'd4;
   assign pc_vec     = {24'b0, vec_q};
   assign cause      = cause_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer (default MEM_LAT = 2, VEC_BASE = 253).
module tb_exception_sequencer;

   localparam int LAT = 2;

   logic        clk;
   logic        reset;
   logic        exc_opcode, exc_ovf, exc_div0;
   logic [1:0]  ctrl_iord;
   logic [31:0] pc_i;
   logic [31:0] mem_rdata;
   logic [1:0]  iord_sel;
   logic [31:0] excpt_addr;
   logic        busy, epc_wr, pc_wr;
   logic [31:0] epc_val, pc_vec;
   logic [1:0]  cause;
   logic [2:0]  state_dbg;
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
   logic        double_fault;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   exception_sequencer #(.MEM_LAT(LAT), .VEC_BASE(253)) dut (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
      .ctrl_iord(ctrl_iord), .pc_i(pc_i), .mem_rdata(mem_rdata),
      .iord_sel(iord_sel), .excpt_addr(excpt_addr), .busy(busy),
      .epc_wr(epc_wr), .epc_val(epc_val), .pc_wr(pc_wr), .pc_vec(pc_vec),
      .cause(cause),
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
      .double_fault(double_fault),
`endif
      .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full sequence; the correct vector byte is on mem_rdata only in the last WAIT cycle.
   task automatic run_seq(input string tag, input logic [2:0] req, input logic [31:0] pc,
                          input logic [7:0] vec, input logic [1:0] exp_cause,
                          input logic [31:0] exp_addr, input logic [31:0] exp_epc);
      int nbusy = 0;
      int nepc  = 0;
      int npc   = 0;
      pc_i = pc;
      {exc_opcode, exc_ovf, exc_div0} = req;
      mem_rdata = 32'hDEAD_BEEE;
      exp_q.push_back({24'h0, vec});
      tick();
      {exc_opcode, exc_ovf, exc_div0} = 3'b000;
      ctrl_iord = 2'b01;
      for (int k = 0; k < 20; k++) begin
         mem_rdata = (k == LAT) ? {24'h5A5A5A, vec} : 32'hDEAD_BEEE;
         #1;
         if (!busy) break;
         nbusy++;
         chk({tag, "_iord_busy"}, iord_sel, 32'd3);
         chk({tag, "_wr_excl"}, epc_wr & pc_wr, 32'd0);
         if (epc_wr) begin
            nepc++;
            chk({tag, "_epc_val"}, epc_val, exp_epc);
            chk({tag, "_cause"}, cause, exp_cause);
            chk({tag, "_excpt_addr"}, excpt_addr, exp_addr);
         end
         if (pc_wr) begin
            npc++;
            chk({tag, "_addr_held"}, excpt_addr, exp_addr);
            if (exp_q.size() > 0)
               chk({tag, "_pc_vec"}, pc_vec, exp_q.pop_front());
         end
         tick();
      end
      chk({tag, "_busy_len"}, nbusy, LAT + 2);
      chk({tag, "_epc_pulses"}, nepc, 1);
      chk({tag, "_pc_pulses"}, npc, 1);
      chk({tag, "_iord_idle"}, iord_sel, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      {exc_opcode, exc_ovf, exc_div0} = 3'b111;
      ctrl_iord = 2'b10;
      pc_i = 32'h0;
      mem_rdata = 32'h0;

      // reset held two cycles with every request active
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_iord", iord_sel, 32'd0);
         chk("rst_busy", busy, 32'd0);
         chk("rst_epc_wr", epc_wr, 32'd0);
         chk("rst_pc_wr", pc_wr, 32'd0);
         chk("rst_state", state_dbg, 32'd0);
      end
      chk("rst_excpt_addr", excpt_addr, 32'd253);
      chk("rst_cause", cause, 32'd0);
      chk("rst_pc_vec", pc_vec, 32'd0);
      chk("rst_epc_val", epc_val, 32'hFFFF_FFFC);
      reset = 1'b0;
      {exc_opcode, exc_ovf, exc_div0} = 3'b000;
      #1;
      chk("rel_iord", iord_sel, 32'd2);
      tick();
      chk("rel_state", state_dbg, 32'd0);

      // pass-through in IDLE
      for (int v = 0; v < 4; v++) begin
         ctrl_iord = 2'(v);
         #1;
         chk("pass_iord", iord_sel, 32'(v));
      end
      tick();

      run_seq("ovf", 3'b010, 32'h0000_0040, 8'h7C, 2'd1, 32'd254, 32'h0000_003C);
      tick();
      run_seq("prio", 3'b111, 32'h0000_0100, 8'h11, 2'd0, 32'd253, 32'h0000_00FC);
      tick();
      run_seq("div0", 3'b001, 32'h0000_0000, 8'hA5, 2'd2, 32'd255, 32'hFFFF_FFFC);
      chk("scoreboard_empty", exp_q.size(), 0);
      tick();

      // reset during the second (last) WAIT cycle
      exc_opcode = 1'b1;
      tick();
      exc_opcode = 1'b0;
      tick();
      tick();
      chk("midrst_in_wait", state_dbg, 32'd2);
      reset = 1'b1;
      mem_rdata = 32'h0000_0077;
      #1;
      chk("midrst_iord_forced", iord_sel, 32'd0);
      tick();
      chk("midrst_state", state_dbg, 32'd0);
      chk("midrst_busy", busy, 32'd0);
      chk("midrst_pc_wr", pc_wr, 32'd0);
      chk("midrst_pc_vec", pc_vec, 32'd0);
      reset = 1'b0;
      tick();
      chk("midrst_pc_wr2", pc_wr, 32'd0);
      chk("midrst_busy2", busy, 32'd0);

      // request raised while busy
      mem_rdata = 32'h0000_0033;
      exc_ovf = 1'b1;
      tick();
      exc_ovf = 1'b0;
      tick();
      exc_div0 = 1'b1;
      tick();
      exc_div0 = 1'b0;
      tick();
      chk("dbl_load_pc_wr", pc_wr, 32'd1);
      chk("dbl_load_pc_vec", pc_vec, 32'h33);
      tick();
      chk("dbl_cause_kept", cause, 32'd1);
`ifdef EXC_SEQ_DOUBLE_FAULT_EN
      chk("dbl_flag", double_fault, 32'd1);
      chk("dbl_halt_busy", busy, 32'd1);
      chk("dbl_halt_iord", iord_sel, 32'd3);
      tick();
      tick();
      chk("dbl_halt_hold", busy, 32'd1);
      chk("dbl_halt_pc_wr", pc_wr, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("dbl_clr_flag", double_fault, 32'd0);
      chk("dbl_clr_busy", busy, 32'd0);
`else
      chk("dbl_idle_busy", busy, 32'd0);
      chk("dbl_idle_state", state_dbg, 32'd0);
      tick();
      chk("dbl_idle_stays", busy, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
